// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    ALLOC = 2'd2,
    RETRY = 2'd3
  } stateT;

  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = 2;

  function automatic logic [OFFSET_W-1:0] addrOffset(input logic [15:0] addr);
    return addr[OFFSET_W:1];
  endfunction

  // Index and tag are returned right-aligned; callers size-cast to their field width.
  function automatic logic [15:0] addrIndex(input logic [15:0] addr, input int indexW);
    return (addr >> 3) & ((16'd1 << indexW) - 16'd1);
  endfunction

  function automatic logic [15:0] addrTag(input logic [15:0] addr, input int indexW);
    return addr >> (3 + indexW);
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Processor-side and memory-side bus of the data cache; slave is the cache's view.
interface dcache_if;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, Done, Stall, CacheHit, CacheReq, Err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ack;

  // Requests are held stable while Stall=1; mem_rd/mem_wr are held until mem_ack.
  modport slave (
    input  Addr, DataIn, Rd, Wr, mem_rdata, mem_ack,
    output DataOut, Done, Stall, CacheHit, CacheReq, Err,
           mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport master (
    output Addr, DataIn, Rd, Wr, mem_rdata, mem_ack,
    input  DataOut, Done, Stall, CacheHit, CacheReq, Err,
           mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one registered write port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 16 - 3 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rdIndex,
  input  logic [OFFSET_W-1:0] rdOffset,
  output logic [TAG_W-1:0]   rdTag,
  output logic               rdValid,
  output logic               rdDirty,
  output logic [15:0]        rdWord,
  input  logic [INDEX_W-1:0] wrIndex,
  input  logic [OFFSET_W-1:0] wrOffset,
  input  logic [15:0]        wrData,
  input  logic               dataWe,
  input  logic               dirtySet,
  input  logic               fillDone,
  input  logic [TAG_W-1:0]   fillTag
);
  localparam int LINES = 2 ** INDEX_W;

  logic [15:0]      dataMem [LINES*LINE_WORDS];
  logic [TAG_W-1:0] tagMem  [LINES];
  logic [LINES-1:0] validBits, dirtyBits;

  assign rdTag   = tagMem[rdIndex];
  assign rdValid = validBits[rdIndex];
  assign rdDirty = dirtyBits[rdIndex];
  assign rdWord  = dataMem[{rdIndex, rdOffset}];

  // Only the status bits are cleared; stale data and tags are harmless once invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validBits <= '0;
      dirtyBits <= '0;
    end else if (fillDone) begin
      validBits[wrIndex] <= 1'b1;
      dirtyBits[wrIndex] <= 1'b0;
    end else if (dirtySet) begin
      dirtyBits[wrIndex] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (dataWe)   dataMem[{wrIndex, wrOffset}] <= wrData;
    if (fillDone) tagMem[wrIndex] <= fillTag;
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Optional hit/request statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_W     = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  dcache_if.slave     bus,
  output logic        err_timeout,
  output logic [15:0] hit_count,
  output logic [15:0] req_count,
  output stateT       dbgState
);
  localparam int TAG_W = 16 - 3 - INDEX_W;
  localparam int TO_W  = $clog2(MEM_TIMEOUT + 1);

  stateT               state;
  logic [OFFSET_W-1:0] cnt;
  logic [TO_W-1:0]     toCnt;

  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic [OFFSET_W-1:0] offset;
  logic [TAG_W-1:0]    rdTag;
  logic                rdValid, rdDirty;
  logic [15:0]         rdWord;

  logic idle, inWb, inAlloc, inRetry;
  logic access, badAcc, goodAcc, hit, idleHit, idleMiss;
  logic done, err, lastWord;

  assign index  = INDEX_W'(addrIndex(bus.Addr, INDEX_W));
  assign tag    = TAG_W'(addrTag(bus.Addr, INDEX_W));
  assign offset = addrOffset(bus.Addr);

  assign idle     = (state == IDLE);
  assign inWb     = (state == WB);
  assign inAlloc  = (state == ALLOC);
  assign inRetry  = (state == RETRY);
  assign lastWord = (cnt == OFFSET_W'(LINE_WORDS - 1));

  assign access   = bus.Rd | bus.Wr;
  assign badAcc   = access & (bus.Addr[0] | (bus.Rd & bus.Wr));
  assign goodAcc  = access & ~badAcc;
  assign hit      = rdValid & (rdTag == tag);
  assign idleHit  = idle & goodAcc & hit;
  assign idleMiss = idle & goodAcc & ~hit;

  // Processor-side outputs are gated by reset so they read 0 while rst is low.
  assign err          = rst & idle & badAcc;
  assign done         = rst & (idleHit | (idle & badAcc) | inRetry);
  assign bus.Done     = done;
  assign bus.Err      = err;
  assign bus.CacheHit = rst & idleHit;
  assign bus.CacheReq = rst & idle & goodAcc;
  assign bus.Stall    = rst & (idleMiss | inWb | inAlloc);
  assign bus.DataOut  = (done & ~err) ? rdWord : 16'h0;

  assign bus.mem_wr    = inWb;
  assign bus.mem_rd    = inAlloc;
  assign bus.mem_wdata = inWb ? rdWord : 16'h0;
  assign bus.mem_addr  = inWb    ? {rdTag, index, cnt, 1'b0} :
                         inAlloc ? {tag,   index, cnt, 1'b0} : 16'h0;
  assign dbgState      = state;

  dcache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
    .clk      (clk),
    .rst      (rst),
    .rdIndex  (index),
    .rdOffset (inWb ? cnt : offset),
    .rdTag    (rdTag),
    .rdValid  (rdValid),
    .rdDirty  (rdDirty),
    .rdWord   (rdWord),
    .wrIndex  (index),
    .wrOffset (inAlloc ? cnt : offset),
    .wrData   (inAlloc ? bus.mem_rdata : bus.DataIn),
    .dataWe   ((idleHit & bus.Wr) | (inAlloc & bus.mem_ack) | (inRetry & bus.Wr & ~bus.Rd)),
    .dirtySet ((idleHit | inRetry) & bus.Wr & ~bus.Rd),
    .fillDone (inAlloc & bus.mem_ack & lastWord),
    .fillTag  (tag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (idleMiss) begin
          state <= (rdValid & rdDirty) ? WB : ALLOC;
          cnt   <= '0;
        end
        WB: if (bus.mem_ack) begin
          cnt <= cnt + OFFSET_W'(1);
          if (lastWord) state <= ALLOC;
        end
        ALLOC: if (bus.mem_ack) begin
          cnt <= cnt + OFFSET_W'(1);
          if (lastWord) state <= RETRY;
        end
        RETRY:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The flag is sticky but the FSM keeps waiting for the late ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toCnt       <= '0;
      err_timeout <= 1'b0;
    end else if ((bus.mem_rd | bus.mem_wr) & ~bus.mem_ack) begin
      if (toCnt != TO_W'(MEM_TIMEOUT))     toCnt <= toCnt + TO_W'(1);
      if (toCnt == TO_W'(MEM_TIMEOUT - 1)) err_timeout <= 1'b1;
    end else begin
      toCnt <= '0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hitCnt, reqCnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hitCnt <= '0;
      reqCnt <= '0;
    end else begin
      if (bus.CacheHit && done && hitCnt != 16'hFFFF) hitCnt <= hitCnt + 16'd1;
      if (bus.CacheReq && reqCnt != 16'hFFFF)          reqCnt <= reqCnt + 16'd1;
    end
  end
  assign hit_count = hitCnt;
  assign req_count = reqCnt;
`else
  assign hit_count = 16'h0;
  assign req_count = 16'h0;
`endif
endmodule
